// File: rtl/uart_tx_sched.sv
// Arbitrates echoed receive bytes (small FIFO) and host bytes onto a single UART transmitter.
// Define UART_SCHED_RR_EN for round-robin arbitration; otherwise the echo FIFO has fixed priority.
module uart_tx_sched #(
  parameter int FIFO_AW  = 2,
  parameter int BUSY_TMO = 15
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             rx_busy,
  input  logic [7:0]       rx_data,
  input  logic             tx_busy,
  output logic             tx_wr,
  output logic [7:0]       tx_data,
  input  logic             host_valid,
  input  logic [7:0]       host_data,
  output logic             host_ready,
  input  logic             echo_en,
  output logic [FIFO_AW:0] echo_count,
  output logic             echo_ovf,
  output logic             grant_host
);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0] FULL_CNT = {1'b1, {FIFO_AW{1'b0}}};
  localparam int TW = (BUSY_TMO > 1) ? $clog2(BUSY_TMO) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(BUSY_TMO - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE} state_t;
  state_t state_q, state_d;

  logic               rx_busy_q;
  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [FIFO_AW:0]   count_q, count_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         tx_data_q, tx_data_d;
  logic               grant_host_q, grant_host_d;
  logic [TW-1:0]      tmo_q, tmo_d;
  logic               rx_done, fifo_empty, fifo_full, pending, grant, pick_host, push, pop;

  assign rx_done    = rx_busy_q & ~rx_busy;
  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == FULL_CNT);
  assign pending    = ~fifo_empty | host_valid;
  assign grant      = (state_q == IDLE) & ~tx_busy & pending;

`ifdef UART_SCHED_RR_EN
  logic prio_host_q;

  // prio_host_q points at the source that did not win the previous grant
  assign pick_host = host_valid & (fifo_empty | prio_host_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prio_host_q <= 1'b0;
    end else if (grant) begin
      prio_host_q <= ~pick_host;
    end
  end
`else
  assign pick_host = host_valid & fifo_empty;
`endif

  assign pop  = grant & ~pick_host;
  // A pop in the same cycle frees the slot, so a full FIFO can still accept
  assign push = rx_done & echo_en & (~fifo_full | pop);

  always_comb begin
    state_d      = state_q;
    tmo_d        = tmo_q;
    tx_data_d    = tx_data_q;
    grant_host_d = grant_host_q;
    count_d      = count_q;
    ovf_d        = ovf_q;
    tx_wr        = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant) begin
          state_d      = ISSUE;
          grant_host_d = pick_host;
          tx_data_d    = pick_host ? host_data : mem[rd_ptr_q];
        end
      end
      ISSUE: begin
        tx_wr   = 1'b1;
        tmo_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = WAIT_DONE;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      WAIT_DONE: begin
        if (!tx_busy) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (push & ~pop) begin
      count_d = count_q + 1'b1;
    end else if (pop & ~push) begin
      count_d = count_q - 1'b1;
    end
    if (rx_done & echo_en & ~push) ovf_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      rx_busy_q    <= 1'b0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      ovf_q        <= 1'b0;
      tx_data_q    <= 8'h00;
      grant_host_q <= 1'b0;
      tmo_q        <= '0;
    end else begin
      state_q      <= state_d;
      rx_busy_q    <= rx_busy;
      count_q      <= count_d;
      ovf_q        <= ovf_d;
      tx_data_q    <= tx_data_d;
      grant_host_q <= grant_host_d;
      tmo_q        <= tmo_d;
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
    end
  end

  // host_ready is combinational, so it is masked while reset is held
  assign host_ready = grant & pick_host & ~reset;
  assign tx_data    = tx_data_q;
  assign echo_count = count_q;
  assign echo_ovf   = ovf_q;
  assign grant_host = grant_host_q;
endmodule
